alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares one 4-bit carry-lookahead ALU instance (ALUCLA) between two requesters, using round-robin arbitration.
- Latches the granted request's operands and drives the ALU from registers.
- Waits a fixed settle time for the gate-delay datapath, then captures result/overflow/zero.
- Returns the captured values to the winning requester over a valid/ready response channel.
- Sits between the ALU and the two client blocks; the ALU stays a separate instance at the parent level.

Parameters:
SETTLE_CYCLES, 2, clock cycles the ALU inputs are held stable before outputs are sampled; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has an operation pending
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  4  operand A, requester 0
req0_b  in  4  operand B, requester 0
req0_op  in  2  operation code, requester 0
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 consumes result
rsp0_result  out  4  result for requester 0
rsp0_overflow  out  1  overflow flag for requester 0
rsp0_zero  out  1  zero flag for requester 0
req1_*, rsp1_*  same set as requester 0, same widths and meanings, for requester 1
alu_a  out  4  registered operand A to ALU
alu_b  out  4  registered operand B to ALU
alu_op  out  2  registered op to ALU
alu_result  in  4  ALU result
alu_overflow  in  1  ALU overflow
alu_zero  in  1  ALU zero
busy  out  1  high in any state other than IDLE

Behaviour:
- Op encoding, passed through unchanged to the ALU:
  - 00 ADD: A+B
  - 01 SUB: A-B
  - 10 ABSDIFF: |A-B|
  - 11 AVG: (A+B) arithmetic-shifted right by 1
- Reset, while rst=1 at a clk edge:
  - state=IDLE; last_grant=1, so requester 0 wins the first contention.
  - alu_a/alu_b/alu_op=0; result/flag registers=0.
  - All ready/valid outputs 0; busy=0.
- Reset mid-operation aborts the operation; no response is ever issued for it.
- States: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready = grant_N, combinational from the arbiter; at most one grant per cycle.
  - Grant goes to the sole valid requester. If both are valid, it goes to the requester that is not last_grant.
  - On a grant, register a/b/op into alu_a/alu_b/alu_op, set owner=N and cnt=SETTLE_CYCLES-1, then go to EXEC.
  - A requester that drops valid before ready has no effect.
- EXEC:
  - alu_* held constant; the other requester's ready=0.
  - cnt decrements each cycle. When cnt==0, capture alu_result/overflow/zero into the response registers and go to RESP.
  - EXEC therefore lasts exactly SETTLE_CYCLES cycles.
- RESP:
  - rsp<owner>_valid=1 with the registered result/flags; the other rsp valid stays 0.
  - Data holds stable until rsp<owner>_ready=1. On that cycle: last_grant=owner, state goes to IDLE, rsp valid drops the next cycle.
  - No new request is accepted in RESP.
  - A new request asserted during EXEC/RESP waits and is granted in the next IDLE cycle.
- Latency:
  - Request accept to rsp_valid = SETTLE_CYCLES+1 cycles.
  - Minimum issue interval = SETTLE_CYCLES+2 cycles.
- Widths: all data is 4 bits, no internal arithmetic; wrap/overflow semantics belong to the ALU.
- Fairness: under continuous requests from both sides, grants alternate 0,1,0,1.

Decomposition:
- Package alu_ctrl_pkg:
  - op enum: OP_ADD, OP_SUB, OP_ABSDIFF, OP_AVG.
  - state enum: IDLE, EXEC, RESP.
  - constant ALU_W=4.
- Sub-module rr_arbiter2:
  - Inputs: two valids, last_grant, enable.
  - Outputs: one-hot grant[1:0].
  - Purely combinational; last_grant register stays in the parent.
- The ALU is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then req0 ADD a=3 b=4 (SETTLE_CYCLES=2) -> req0_ready in the same cycle; rsp0_valid 3 cycles later with result=7, overflow=0, zero=0; busy high throughout.
- req1 SUB a=5 b=5 -> rsp1 result=0, zero=1, overflow=0; rsp0_valid stays 0.
- req0 ABSDIFF a=2 b=6 -> result=4; then req1 ADD a=7 b=1 -> result=8 (1000b), overflow=1.
- req0 AVG a=2 b=4 -> result=3.
- Both valid continuously from reset, rsp_ready tied 1 -> grants alternate 0,1,0,1. Each accept comes 4 cycles after the previous one, and each response pairs with its own operands.
- Hold rsp0_ready=0 for 5 cycles in RESP -> rsp0 data stable and req1_ready=0 throughout. Assert rst during EXEC -> next cycle IDLE, busy=0, no rsp_valid, alu_* = 0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sharing arbiter.
package alu_ctrl_pkg;

    localparam int ALU_W = 4;
    localparam int OP_W  = 2;
    localparam int CNT_W = 4;

    // Operation codes, passed to the ALU unchanged.
    typedef enum logic [OP_W-1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ABSDIFF = 2'b10,
        OP_AVG     = 2'b11
    } alu_op_e;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic. The last_grant history register lives
// in the parent; this block is purely combinational.
module rr_arbiter2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    // Sole requester wins; on contention the requester not granted last wins.
    always_comb begin
        grant    = 2'b00;
        grant[0] = enable & valid0 & (~valid1 | last_grant);
        grant[1] = enable & valid1 & (~valid0 | ~last_grant);
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external 4-bit ALU between two requesters. The granted
// operands are registered onto alu_*, held for SETTLE_CYCLES cycles so the
// gate-delay datapath settles, then the result/flags are captured and
// returned on the owner's response channel.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. Requesters hold payload stable while valid is high and ready
// is low. rspN_valid, once raised, stays high with stable data until the
// edge where rspN_ready is sampled high.
module alu_share_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2  // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [ALU_W-1:0] req0_a,
    input  logic [ALU_W-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [ALU_W-1:0] rsp0_result,
    output logic             rsp0_overflow,
    output logic             rsp0_zero,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [ALU_W-1:0] req1_a,
    input  logic [ALU_W-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [ALU_W-1:0] rsp1_result,
    output logic             rsp1_overflow,
    output logic             rsp1_zero,

    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [ALU_W-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_zero,

    output logic             busy
);

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ALU_W-1:0]   alu_a_q, alu_a_d;
    logic [ALU_W-1:0]   alu_b_q, alu_b_d;
    logic [OP_W-1:0]    alu_op_q, alu_op_d;
    logic [ALU_W-1:0]   res_q, res_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [1:0]         grant;
    logic               arb_enable;

    // Grants are only offered in IDLE and never while reset is applied.
    assign arb_enable = (state_q == IDLE) && !rst;

    rr_arbiter2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .enable     (arb_enable),
        .grant      (grant)
    );

    // Next-state and datapath register updates for IDLE -> EXEC -> RESP.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        res_d        = res_q;
        ovf_d        = ovf_q;
        zero_d       = zero_q;

        case (state_q)
            IDLE: begin
                if (grant[1]) begin
                    alu_a_d  = req1_a;
                    alu_b_d  = req1_b;
                    alu_op_d = req1_op;
                    owner_d  = 1'b1;
                    cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
                    state_d  = EXEC;
                end else if (grant[0]) begin
                    alu_a_d  = req0_a;
                    alu_b_d  = req0_b;
                    alu_op_d = req0_op;
                    owner_d  = 1'b0;
                    cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // The counter reaching zero marks the last settle cycle.
                if (cnt_q == '0) begin
                    res_d   = alu_result;
                    ovf_d   = alu_overflow;
                    zero_d  = alu_zero;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if ((owner_q == 1'b0 && rsp0_ready) || (owner_q == 1'b1 && rsp1_ready)) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            res_q        <= '0;
            ovf_q        <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            res_q        <= res_d;
            ovf_q        <= ovf_d;
            zero_q       <= zero_d;
        end
    end

    // Output decode: ready straight from the arbiter, response from registers.
    always_comb begin
        req0_ready    = grant[0];
        req1_ready    = grant[1];
        rsp0_valid    = (state_q == RESP) && (owner_q == 1'b0);
        rsp1_valid    = (state_q == RESP) && (owner_q == 1'b1);
        rsp0_result   = res_q;
        rsp0_overflow = ovf_q;
        rsp0_zero     = zero_q;
        rsp1_result   = res_q;
        rsp1_overflow = ovf_q;
        rsp1_zero     = zero_q;
        alu_a         = alu_a_q;
        alu_b         = alu_b_q;
        alu_op        = alu_op_q;
        busy          = (state_q != IDLE);
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU stands in for the parent's
// instance; a cycle-level reference model predicts grants, latency and
// responses, and scenario tasks add targeted checks.
module tb_alu_share_arbiter;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0] req0_op = '0, req1_op = '0;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [3:0] rsp0_result, rsp1_result;
    logic       rsp0_overflow, rsp1_overflow, rsp0_zero, rsp1_zero;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [1:0] alu_op;
    logic       alu_overflow, alu_zero;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_overflow(rsp0_overflow), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_overflow(rsp1_overflow), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .busy(busy)
    );

    // Arithmetic meaning of each op on 4-bit two's-complement operands.
    // Returns {zero, overflow, result}.
    function automatic logic [5:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        int sa, sb, s;
        logic ovf;
        logic [3:0] r;
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        case (op)
            2'd0: begin s = sa + sb; ovf = (s > 7) || (s < -8); end
            2'd1: begin s = sa - sb; ovf = (s > 7) || (s < -8); end
            2'd2: begin s = sa - sb; if (s < 0) s = -s; ovf = (s > 7); end
            default: begin s = (sa + sb) >>> 1; ovf = 1'b0; end
        endcase
        r = s[3:0];
        return {(r == 4'd0), ovf, r};
    endfunction

    // Behavioural ALU seen by the DUT.
    logic [5:0] alu_bus;
    always_comb alu_bus = alu_ref(alu_a, alu_b, alu_op);
    assign alu_result   = alu_bus[3:0];
    assign alu_overflow = alu_bus[4];
    assign alu_zero     = alu_bus[5];

    // Reference model: m_age = cycles since accept (-1 when nothing in flight).
    int         m_age = -1;
    logic       m_owner = 1'b0;
    logic       m_last  = 1'b1;
    logic [3:0] m_a = '0, m_b = '0;
    logic [1:0] m_op = '0;
    logic [5:0] exp_q[$];
    int         cyc = 0;

    // Observed accepts, for fairness and spacing checks.
    bit         obs_grant[$];
    int         obs_cyc[$];
    bit         last_acc0, last_acc1;

    // One clock cycle: check DUT against the model, clock, advance the model.
    task automatic cycle();
        bit eg0, eg1, ev0, ev1;
        #1;
        eg0 = !rst && (m_age < 0) && req0_valid && (!req1_valid || m_last == 1'b1);
        eg1 = !rst && (m_age < 0) && req1_valid && (!req0_valid || m_last == 1'b0);
        ev0 = (m_age >= S) && (m_owner == 1'b0);
        ev1 = (m_age >= S) && (m_owner == 1'b1);

        total++;
        if (req0_ready !== eg0) begin bad++; $display("FAIL req0_ready cyc=%0d: got %b expected %b", cyc, req0_ready, eg0); end
        total++;
        if (req1_ready !== eg1) begin bad++; $display("FAIL req1_ready cyc=%0d: got %b expected %b", cyc, req1_ready, eg1); end
        total++;
        if (busy !== (m_age >= 0)) begin bad++; $display("FAIL busy cyc=%0d: got %b expected %b", cyc, busy, (m_age >= 0)); end
        total++;
        if ({alu_a, alu_b, alu_op} !== {m_a, m_b, m_op}) begin
            bad++; $display("FAIL alu_inputs cyc=%0d: got %h/%h/%h expected %h/%h/%h", cyc, alu_a, alu_b, alu_op, m_a, m_b, m_op);
        end
        total++;
        if (rsp0_valid !== ev0) begin bad++; $display("FAIL rsp0_valid cyc=%0d: got %b expected %b", cyc, rsp0_valid, ev0); end
        total++;
        if (rsp1_valid !== ev1) begin bad++; $display("FAIL rsp1_valid cyc=%0d: got %b expected %b", cyc, rsp1_valid, ev1); end
        if ((ev0 || ev1) && exp_q.size() > 0) begin
            total++;
            if (ev0 && {rsp0_zero, rsp0_overflow, rsp0_result} !== exp_q[0]) begin
                bad++; $display("FAIL rsp0_data cyc=%0d: got %h expected %h", cyc, {rsp0_zero, rsp0_overflow, rsp0_result}, exp_q[0]);
            end
            if (ev1 && {rsp1_zero, rsp1_overflow, rsp1_result} !== exp_q[0]) begin
                bad++; $display("FAIL rsp1_data cyc=%0d: got %h expected %h", cyc, {rsp1_zero, rsp1_overflow, rsp1_result}, exp_q[0]);
            end
        end

        last_acc0 = req0_valid && req0_ready;
        last_acc1 = req1_valid && req1_ready;
        if (last_acc0 || last_acc1) begin
            obs_grant.push_back(last_acc1);
            obs_cyc.push_back(cyc);
        end

        @(posedge clk);
        if (rst) begin
            m_age = -1; m_last = 1'b1; m_a = '0; m_b = '0; m_op = '0;
            exp_q.delete();
        end else if (m_age < 0) begin
            if (eg0 || eg1) begin
                m_owner = eg1;
                m_a  = eg1 ? req1_a  : req0_a;
                m_b  = eg1 ? req1_b  : req0_b;
                m_op = eg1 ? req1_op : req0_op;
                exp_q.push_back(alu_ref(m_a, m_b, m_op));
                m_age = 0;
            end
        end else if (m_age >= S) begin
            if ((m_owner == 1'b0 && rsp0_ready) || (m_owner == 1'b1 && rsp1_ready)) begin
                m_last = m_owner;
                m_age  = -1;
                void'(exp_q.pop_front());
            end
        end else begin
            m_age++;
        end
        cyc++;
        #1;
    endtask

    // Drive one transaction from requester n and return what the DUT responded.
    task automatic run_txn(input bit n, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                           output logic [3:0] r, output logic o, output logic z, output int lat);
        if (n) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; rsp1_ready = 1'b1; end
        else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; rsp0_ready = 1'b1; end
        cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 1;
        while (!(n ? rsp1_valid : rsp0_valid) && lat < 20) begin
            cycle();
            lat++;
        end
        r = n ? rsp1_result   : rsp0_result;
        o = n ? rsp1_overflow : rsp0_overflow;
        z = n ? rsp1_zero     : rsp0_zero;
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++;
        if ({alu_a, alu_b, alu_op} !== 10'd0) begin bad++; $display("FAIL reset_alu: got %h expected 0", {alu_a, alu_b, alu_op}); end
        total++;
        if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 4'b0) begin
            bad++; $display("FAIL reset_handshake: got %b expected 0000", {rsp0_valid, rsp1_valid, req0_ready, req1_ready});
        end
        total++;
        if ({rsp0_result, rsp0_overflow, rsp0_zero} !== 6'd0) begin
            bad++; $display("FAIL reset_rsp_regs: got %h expected 0", {rsp0_result, rsp0_overflow, rsp0_zero});
        end
        m_age = -1; m_last = 1'b1; m_a = '0; m_b = '0; m_op = '0; exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [3:0] r; logic o, z; int lat;
        run_txn(1'b0, 4'd3, 4'd4, 2'd0, r, o, z, lat);
        total++;
        if (lat !== S + 1) begin bad++; $display("FAIL add_latency: got %0d expected %0d", lat, S + 1); end
        total++;
        if ({r, o, z} !== {4'd7, 1'b0, 1'b0}) begin bad++; $display("FAIL add_result: got %h/%b/%b expected 7/0/0", r, o, z); end
    endtask

    task automatic test_sub_zero();
        logic [3:0] r; logic o, z; int lat;
        run_txn(1'b1, 4'd5, 4'd5, 2'd1, r, o, z, lat);
        total++;
        if ({r, o, z} !== {4'd0, 1'b0, 1'b1}) begin bad++; $display("FAIL sub_zero: got %h/%b/%b expected 0/0/1", r, o, z); end
    endtask

    task automatic test_absdiff_overflow();
        logic [3:0] r; logic o, z; int lat;
        run_txn(1'b0, 4'd2, 4'd6, 2'd2, r, o, z, lat);
        total++;
        if ({r, o, z} !== {4'd4, 1'b0, 1'b0}) begin bad++; $display("FAIL absdiff: got %h/%b/%b expected 4/0/0", r, o, z); end
        run_txn(1'b1, 4'd7, 4'd1, 2'd0, r, o, z, lat);
        total++;
        if ({r, o, z} !== {4'd8, 1'b1, 1'b0}) begin bad++; $display("FAIL add_overflow: got %h/%b/%b expected 8/1/0", r, o, z); end
    endtask

    task automatic test_avg();
        logic [3:0] r; logic o, z; int lat;
        run_txn(1'b0, 4'd2, 4'd4, 2'd3, r, o, z, lat);
        total++;
        if ({r, o, z} !== {4'd3, 1'b0, 1'b0}) begin bad++; $display("FAIL avg: got %h/%b/%b expected 3/0/0", r, o, z); end
    endtask

    task automatic test_fairness();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        obs_grant.delete();
        obs_cyc.delete();
        req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15)); req0_op = 2'($urandom_range(0, 3));
        req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15)); req1_op = 2'($urandom_range(0, 3));
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 34; i++) begin
            cycle();
            if (last_acc0) begin
                req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15)); req0_op = 2'($urandom_range(0, 3));
            end
            if (last_acc1) begin
                req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15)); req1_op = 2'($urandom_range(0, 3));
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < S + 3; i++) cycle();
        total++;
        if (obs_grant.size() < 8) begin bad++; $display("FAIL fair_count: got %0d expected >= 8", obs_grant.size()); end
        for (int i = 0; i < obs_grant.size(); i++) begin
            total++;
            if (obs_grant[i] !== bit'(i % 2)) begin bad++; $display("FAIL fair_order[%0d]: got %0d expected %0d", i, obs_grant[i], i % 2); end
            if (i > 0) begin
                total++;
                if (obs_cyc[i] - obs_cyc[i-1] != S + 2) begin
                    bad++; $display("FAIL fair_spacing[%0d]: got %0d expected %0d", i, obs_cyc[i] - obs_cyc[i-1], S + 2);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [3:0] held; logic ho, hz; int guard;
        req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15)); req0_op = 2'($urandom_range(0, 3));
        req0_valid = 1'b1; rsp0_ready = 1'b0;
        cycle();
        req0_valid = 1'b0;
        req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15)); req1_op = 2'($urandom_range(0, 3));
        req1_valid = 1'b1; rsp1_ready = 1'b1;
        guard = 0;
        while (!rsp0_valid && guard < 20) begin cycle(); guard++; end
        held = rsp0_result; ho = rsp0_overflow; hz = rsp0_zero;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({rsp0_valid, rsp0_result, rsp0_overflow, rsp0_zero, req1_ready} !== {1'b1, held, ho, hz, 1'b0}) begin
                bad++; $display("FAIL hold_stable[%0d]: got v=%b r=%h o=%b z=%b rdy1=%b expected v=1 r=%h o=%b z=%b rdy1=0",
                                i, rsp0_valid, rsp0_result, rsp0_overflow, rsp0_zero, req1_ready, held, ho, hz);
            end
            cycle();
        end
        rsp0_ready = 1'b1;
        cycle();
        #1;
        total++;
        if (req1_ready !== 1'b1) begin bad++; $display("FAIL waiting_req1_grant: got %b expected 1", req1_ready); end
        cycle();
        req1_valid = 1'b0;
        for (int i = 0; i < S + 3; i++) cycle();
    endtask

    task automatic test_reset_mid_exec();
        req0_a = 4'($urandom_range(1, 15)); req0_b = 4'($urandom_range(0, 15)); req0_op = 2'($urandom_range(0, 3));
        req0_valid = 1'b1; rsp0_ready = 1'b1;
        cycle();
        req0_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        total++;
        if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
            bad++; $display("FAIL midreset_state: got busy/v0/v1=%b expected 000", {busy, rsp0_valid, rsp1_valid});
        end
        total++;
        if ({alu_a, alu_b, alu_op} !== 10'd0) begin bad++; $display("FAIL midreset_alu: got %h expected 0", {alu_a, alu_b, alu_op}); end
        for (int i = 0; i < S + 3; i++) cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_sub_zero();
        test_absdiff_overflow();
        test_avg();
        test_fairness();
        test_back_pressure();
        test_reset_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
